// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes, opcode and
// function fields, ALU opcodes and datapath mux selects.
package mc_pkg;

    localparam int          STATE_W = 3;
    localparam logic [31:0] PC_INC  = 32'd4;

    typedef enum logic [STATE_W-1:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_TRAP = 3'b101
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    localparam logic [1:0] ALUSRCB_B    = 2'b00;
    localparam logic [1:0] ALUSRCB_INC  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM  = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_REGA   = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: op/func to instruction-class flags plus the
// ALU opcode, immediate sign-extension and rt-destination select.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output logic       is_ralu,
    output logic       is_ialu,
    output logic       is_lw,
    output logic       is_sw,
    output logic       is_beq,
    output logic       is_bne,
    output logic       is_j,
    output logic       is_jal,
    output logic       is_jr,
    output logic       is_shift,
    output logic       valid,
    output logic [3:0] aluc,
    output logic       sext,
    output logic       regrt
);

    // Classify the instruction and pick its ALU operation.
    always_comb begin
        is_ralu  = 1'b0;
        is_ialu  = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_j     = 1'b0;
        is_jal   = 1'b0;
        is_jr    = 1'b0;
        is_shift = 1'b0;
        aluc     = ALUC_ADD;
        sext     = 1'b1;
        regrt    = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_ADD:  begin is_ralu = 1'b1; aluc = ALUC_ADD; end
                    FN_SUB:  begin is_ralu = 1'b1; aluc = ALUC_SUB; end
                    FN_AND:  begin is_ralu = 1'b1; aluc = ALUC_AND; end
                    FN_OR:   begin is_ralu = 1'b1; aluc = ALUC_OR;  end
                    FN_XOR:  begin is_ralu = 1'b1; aluc = ALUC_XOR; end
                    FN_SLL:  begin is_ralu = 1'b1; is_shift = 1'b1; aluc = ALUC_SLL; end
                    FN_SRL:  begin is_ralu = 1'b1; is_shift = 1'b1; aluc = ALUC_SRL; end
                    FN_SRA:  begin is_ralu = 1'b1; is_shift = 1'b1; aluc = ALUC_SRA; end
                    FN_JR:   begin is_jr = 1'b1; end
                    default: begin is_ralu = 1'b0; end
                endcase
            end
            OP_ADDI: begin is_ialu = 1'b1; regrt = 1'b1; aluc = ALUC_ADD; end
            // Logical immediates are zero-extended.
            OP_ANDI: begin is_ialu = 1'b1; regrt = 1'b1; aluc = ALUC_AND; sext = 1'b0; end
            OP_ORI:  begin is_ialu = 1'b1; regrt = 1'b1; aluc = ALUC_OR;  sext = 1'b0; end
            OP_XORI: begin is_ialu = 1'b1; regrt = 1'b1; aluc = ALUC_XOR; sext = 1'b0; end
            OP_LUI:  begin is_ialu = 1'b1; regrt = 1'b1; aluc = ALUC_LUI; end
            OP_LW:   begin is_lw   = 1'b1; regrt = 1'b1; aluc = ALUC_ADD; end
            OP_SW:   begin is_sw   = 1'b1; aluc = ALUC_ADD; end
            OP_BEQ:  begin is_beq  = 1'b1; aluc = ALUC_SUB; end
            OP_BNE:  begin is_bne  = 1'b1; aluc = ALUC_SUB; end
            OP_J:    begin is_j    = 1'b1; end
            OP_JAL:  begin is_jal  = 1'b1; end
            default: begin is_ralu = 1'b0; end
        endcase
        valid = is_ralu | is_ialu | is_lw | is_sw | is_beq | is_bne | is_j | is_jal | is_jr;
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM (IF/ID/EXE/MEM/WB) driving the ALU and datapath selects.
// Optional MC_CONTROL_ILLEGAL_TRAP_EN: undecoded instructions lock in TRAP with illegal=1.
module mc_control
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    output logic [3:0] aluc,
    output logic       shift,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       sext,
    output logic [1:0] pcsrc,
    output logic       wpc,
    output logic       wir,
    output logic       iord,
    output logic       wmem,
    output logic       wreg,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    output logic       illegal,
`endif
    output logic [2:0] state
);

    state_t     cur;
    state_t     nxt;
    state_t     state_next;
    logic       d_ralu, d_ialu, d_lw, d_sw, d_beq, d_bne, d_j, d_jal, d_jr, d_shift, d_valid;
    logic [3:0] d_aluc;
    logic       d_sext, d_regrt;

    mc_decode u_decode (
        .op       (op),
        .func     (func),
        .is_ralu  (d_ralu),
        .is_ialu  (d_ialu),
        .is_lw    (d_lw),
        .is_sw    (d_sw),
        .is_beq   (d_beq),
        .is_bne   (d_bne),
        .is_j     (d_j),
        .is_jal   (d_jal),
        .is_jr    (d_jr),
        .is_shift (d_shift),
        .valid    (d_valid),
        .aluc     (d_aluc),
        .sext     (d_sext),
        .regrt    (d_regrt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= S_IF;
        end else begin
            cur <= state_next;
        end
    end

    assign state = cur;

    // Next-state and per-state control outputs; reset masks all write enables.
    always_comb begin
        nxt     = S_IF;
        aluc    = ALUC_ADD;
        shift   = 1'b0;
        alusrca = 1'b0;
        alusrcb = ALUSRCB_B;
        sext    = 1'b1;
        pcsrc   = PCSRC_ALU;
        wpc     = 1'b0;
        wir     = 1'b0;
        iord    = 1'b0;
        wmem    = 1'b0;
        wreg    = 1'b0;
        regrt   = 1'b0;
        m2reg   = 1'b0;
        jal     = 1'b0;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
        illegal = 1'b0;
`endif
        case (cur)
            S_IF: begin
                wpc     = 1'b1;
                wir     = 1'b1;
                alusrcb = ALUSRCB_INC;
                nxt     = S_ID;
            end
            S_ID: begin
                // Branch target is precomputed here for a possible taken branch in EXE.
                alusrcb = ALUSRCB_IMM2;
                if (d_j || d_jal) begin
                    wpc   = 1'b1;
                    pcsrc = PCSRC_JUMP;
                    wreg  = d_jal;
                    jal   = d_jal;
                    nxt   = S_IF;
                end else if (d_jr) begin
                    wpc   = 1'b1;
                    pcsrc = PCSRC_REGA;
                    nxt   = S_IF;
                end else if (d_valid) begin
                    nxt = S_EXE;
                end else begin
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
                    nxt = S_TRAP;
`else
                    nxt = S_IF;
`endif
                end
            end
            S_EXE: begin
                alusrca = 1'b1;
                aluc    = d_aluc;
                sext    = d_sext;
                if (d_ralu) begin
                    shift = d_shift;
                    nxt   = S_WB;
                end else if (d_ialu) begin
                    alusrcb = ALUSRCB_IMM;
                    nxt     = S_WB;
                end else if (d_lw || d_sw) begin
                    alusrcb = ALUSRCB_IMM;
                    nxt     = S_MEM;
                end else if ((d_beq && z) || (d_bne && !z)) begin
                    wpc   = 1'b1;
                    pcsrc = PCSRC_BRANCH;
                    nxt   = S_IF;
                end else begin
                    nxt = S_IF;
                end
            end
            S_MEM: begin
                iord = 1'b1;
                if (d_sw) begin
                    wmem = 1'b1;
                    nxt  = S_IF;
                end else if (d_lw) begin
                    nxt = S_WB;
                end else begin
                    nxt = S_IF;
                end
            end
            S_WB: begin
                wreg  = 1'b1;
                regrt = d_regrt;
                m2reg = d_lw;
                nxt   = S_IF;
            end
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                illegal = 1'b1;
                nxt     = S_TRAP;
            end
`endif
            default: begin
                nxt = S_IF;
            end
        endcase
        if (rst) begin
            state_next = S_IF;
            wpc        = 1'b0;
            wir        = 1'b0;
            wmem       = 1'b0;
            wreg       = 1'b0;
        end else begin
            state_next = nxt;
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: the driver queues per-cycle expected controls
// (value plus care-mask), a negedge monitor pops and compares.
module tb_mc_control;

    typedef struct packed {
        logic [2:0] state;
        logic [3:0] aluc;
        logic       shift;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       sext;
        logic [1:0] pcsrc;
        logic       wpc;
        logic       wir;
        logic       iord;
        logic       wmem;
        logic       wreg;
        logic       regrt;
        logic       m2reg;
        logic       jal;
        logic       illegal;
    } ctl_t;

    localparam int CW = $bits(ctl_t);

    typedef struct {
        ctl_t  e;
        ctl_t  m;
        string nm;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] func = 6'd0;
    logic       z = 1'b0;
    logic [3:0] aluc;
    logic       shift, alusrca, sext, wpc, wir, iord, wmem, wreg, regrt, m2reg, jal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] state;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    int  checks = 0;
    int  errors = 0;
    logic rst_drive = 1'b1;
    sb_t sb[$];

    mc_control dut (
        .clk     (clk),
        .rst     (rst),
        .op      (op),
        .func    (func),
        .z       (z),
        .aluc    (aluc),
        .shift   (shift),
        .alusrca (alusrca),
        .alusrcb (alusrcb),
        .sext    (sext),
        .pcsrc   (pcsrc),
        .wpc     (wpc),
        .wir     (wir),
        .iord    (iord),
        .wmem    (wmem),
        .wreg    (wreg),
        .regrt   (regrt),
        .m2reg   (m2reg),
        .jal     (jal),
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
        .illegal (illegal),
`endif
        .state   (state)
    );

    always #5 clk = ~clk;

    // Monitor: compare the DUT's controls against the oldest queued expectation.
    always @(negedge clk) begin
        ctl_t act;
        sb_t  it;
        if (sb.size() > 0) begin
            it = sb.pop_front();
            act.state   = state;
            act.aluc    = aluc;
            act.shift   = shift;
            act.alusrca = alusrca;
            act.alusrcb = alusrcb;
            act.sext    = sext;
            act.pcsrc   = pcsrc;
            act.wpc     = wpc;
            act.wir     = wir;
            act.iord    = iord;
            act.wmem    = wmem;
            act.wreg    = wreg;
            act.regrt   = regrt;
            act.m2reg   = m2reg;
            act.jal     = jal;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
            act.illegal = illegal;
`else
            act.illegal = 1'b0;
`endif
            checks++;
            if ((CW'(act) & CW'(it.m)) !== (CW'(it.e) & CW'(it.m))) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h (care mask %h) at %0t",
                         it.nm, CW'(act) & CW'(it.m), CW'(it.e) & CW'(it.m), CW'(it.m), $time);
            end
        end
    end

    task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic zz,
                         input ctl_t e, input ctl_t m, input string nm);
        sb_t it;
        @(posedge clk);
        #1;
        op   = o;
        func = f;
        z    = zz;
        rst  = rst_drive;
        it.e  = e;
        it.m  = m;
        it.nm = nm;
        sb.push_back(it);
    endtask

    task automatic base(output ctl_t e, output ctl_t m, input logic [2:0] st);
        e = '0;
        m = '0;
        e.state = st;
        m.state = 3'b111;
        m.wpc   = 1'b1;
        m.wir   = 1'b1;
        m.wmem  = 1'b1;
        m.wreg  = 1'b1;
    endtask

    task automatic do_if(input logic [5:0] o, input logic [5:0] f, input string nm);
        ctl_t e, m;
        base(e, m, 3'b000);
        e.wpc = 1'b1; e.wir = 1'b1;
        e.alusrcb = 2'b01; m.alusrcb = 2'b11;
        m.iord = 1'b1; m.alusrca = 1'b1; m.aluc = 4'hF; m.pcsrc = 2'b11;
        issue(o, f, 1'b0, e, m, {nm, "_if"});
    endtask

    task automatic do_id(input logic [5:0] o, input logic [5:0] f, input logic w_pc,
                         input logic [1:0] pcs, input logic w_jal, input string nm);
        ctl_t e, m;
        base(e, m, 3'b001);
        e.alusrcb = 2'b11; m.alusrcb = 2'b11;
        m.alusrca = 1'b1; m.aluc = 4'hF;
        e.sext = 1'b1; m.sext = 1'b1;
        e.wpc = w_pc;
        if (w_pc) begin e.pcsrc = pcs; m.pcsrc = 2'b11; end
        e.wreg = w_jal; e.jal = w_jal; m.jal = 1'b1;
        issue(o, f, 1'b0, e, m, {nm, "_id"});
    endtask

    task automatic do_exe(input logic [5:0] o, input logic [5:0] f, input logic zz,
                          input logic [3:0] ac, input logic [1:0] srcb, input logic chk_shift,
                          input logic sh, input logic chk_sext, input logic sx,
                          input logic w_pc, input string nm);
        ctl_t e, m;
        base(e, m, 3'b010);
        e.aluc = ac; m.aluc = 4'hF;
        e.alusrcb = srcb; m.alusrcb = 2'b11;
        e.alusrca = 1'b1; m.alusrca = 1'b1;
        e.shift = sh; m.shift = chk_shift;
        e.sext = sx; m.sext = chk_sext;
        e.wpc = w_pc;
        if (w_pc) begin e.pcsrc = 2'b01; m.pcsrc = 2'b11; end
        issue(o, f, zz, e, m, {nm, "_exe"});
    endtask

    task automatic do_mem(input logic [5:0] o, input logic w_mem, input string nm);
        ctl_t e, m;
        base(e, m, 3'b011);
        e.iord = 1'b1; m.iord = 1'b1;
        e.wmem = w_mem;
        issue(o, 6'd0, 1'b0, e, m, {nm, "_mem"});
    endtask

    task automatic do_wb(input logic [5:0] o, input logic [5:0] f, input logic rt,
                         input logic m2r, input string nm);
        ctl_t e, m;
        base(e, m, 3'b100);
        e.wreg = 1'b1;
        e.regrt = rt; m.regrt = 1'b1;
        e.m2reg = m2r; m.m2reg = 1'b1;
        issue(o, f, 1'b0, e, m, {nm, "_wb"});
    endtask

    // Reset cycle: enables forced low, state as given (mask 0 = don't care).
    task automatic do_rst(input logic [2:0] st, input logic [2:0] st_mask, input string nm);
        ctl_t e, m;
        base(e, m, st);
        m.state = st_mask;
        issue(6'd0, 6'd0, 1'b0, e, m, {nm, "_rst"});
    endtask

    task automatic alu_r(input logic [5:0] f, input logic [3:0] ac, input logic sh, input string nm);
        do_if(6'd0, f, nm);
        do_id(6'd0, f, 1'b0, 2'b00, 1'b0, nm);
        do_exe(6'd0, f, 1'b0, ac, 2'b00, 1'b1, sh, 1'b0, 1'b0, 1'b0, nm);
        do_wb(6'd0, f, 1'b0, 1'b0, nm);
    endtask

    task automatic alu_i(input logic [5:0] o, input logic [3:0] ac, input logic chk_sx,
                         input logic sx, input string nm);
        do_if(o, 6'd0, nm);
        do_id(o, 6'd0, 1'b0, 2'b00, 1'b0, nm);
        do_exe(o, 6'd0, 1'b0, ac, 2'b10, 1'b0, 1'b0, chk_sx, sx, 1'b0, nm);
        do_wb(o, 6'd0, 1'b1, 1'b0, nm);
    endtask

    task automatic branch(input logic [5:0] o, input logic zz, input logic taken, input string nm);
        do_if(o, 6'd0, nm);
        do_id(o, 6'd0, 1'b0, 2'b00, 1'b0, nm);
        do_exe(o, 6'd0, zz, 4'b0100, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, taken, nm);
    endtask

    initial begin
        ctl_t e, m;
        int   guard;
        // Power-up reset for two cycles.
        rst_drive = 1'b1;
        do_rst(3'b000, 3'b111, "reset0");
        do_rst(3'b000, 3'b111, "reset1");
        rst_drive = 1'b0;

        alu_r(6'b100000, 4'b0000, 1'b0, "add");
        alu_r(6'b100010, 4'b0100, 1'b0, "sub");
        alu_r(6'b000011, 4'b1111, 1'b1, "sra");
        alu_r(6'b000000, 4'b0011, 1'b1, "sll");
        alu_i(6'b001101, 4'b0101, 1'b1, 1'b0, "ori");
        alu_i(6'b001000, 4'b0000, 1'b1, 1'b1, "addi");
        alu_i(6'b001111, 4'b0110, 1'b0, 1'b0, "lui");

        // lw: five states, MEM reads via ALUout, WB from memory into rt.
        do_if(6'b100011, 6'd0, "lw");
        do_id(6'b100011, 6'd0, 1'b0, 2'b00, 1'b0, "lw");
        do_exe(6'b100011, 6'd0, 1'b0, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "lw");
        do_mem(6'b100011, 1'b0, "lw");
        do_wb(6'b100011, 6'd0, 1'b1, 1'b1, "lw");
        // sw: MEM writes and returns to IF.
        do_if(6'b101011, 6'd0, "sw");
        do_id(6'b101011, 6'd0, 1'b0, 2'b00, 1'b0, "sw");
        do_exe(6'b101011, 6'd0, 1'b0, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "sw");
        do_mem(6'b101011, 1'b1, "sw");

        branch(6'b000100, 1'b1, 1'b1, "beq_z1");
        branch(6'b000100, 1'b0, 1'b0, "beq_z0");
        branch(6'b000101, 1'b0, 1'b1, "bne_z0");
        branch(6'b000101, 1'b1, 1'b0, "bne_z1");

        do_if(6'b000010, 6'd0, "j");
        do_id(6'b000010, 6'd0, 1'b1, 2'b11, 1'b0, "j");
        do_if(6'b000011, 6'd0, "jal");
        do_id(6'b000011, 6'd0, 1'b1, 2'b11, 1'b1, "jal");
        do_if(6'd0, 6'b001000, "jr");
        do_id(6'd0, 6'b001000, 1'b1, 2'b10, 1'b0, "jr");

        // Reset in WB aborts the write and restarts from IF.
        do_if(6'd0, 6'b100000, "abort");
        do_id(6'd0, 6'b100000, 1'b0, 2'b00, 1'b0, "abort");
        do_exe(6'd0, 6'b100000, 1'b0, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "abort");
        rst_drive = 1'b1;
        do_rst(3'b100, 3'b111, "abort_wb");
        rst_drive = 1'b0;

        // Undecoded op.
        do_if(6'b111111, 6'd0, "undef");
        do_id(6'b111111, 6'd0, 1'b0, 2'b00, 1'b0, "undef");
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            base(e, m, 3'b101);
            e.illegal = 1'b1; m.illegal = 1'b1;
            issue(6'b111111, 6'd0, 1'b0, e, m, "trap_hold");
        end
        rst_drive = 1'b1;
        do_rst(3'b101, 3'b111, "trap");
        rst_drive = 1'b0;
        base(e, m, 3'b000);
        e.illegal = 1'b0; m.illegal = 1'b1;
        e.wpc = 1'b1; e.wir = 1'b1;
        issue(6'd0, 6'd0, 1'b0, e, m, "trap_exit_if");
`else
        do_if(6'd0, 6'b100000, "undef_nop");
`endif
        do_id(6'd0, 6'b100000, 1'b0, 2'b00, 1'b0, "after");

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
